// File: rtl/mips_ctrl_fsm_pkg.sv
// Shared encodings for the MIPS multi-cycle control FSM: states, opcodes,
// funct codes, ALU select codes and the decoded instruction class.
package mips_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_IMM_ALU = 3'd1,
    CLS_LW      = 3'd2,
    CLS_SW      = 3'd3,
    CLS_BEQ     = 3'd4
  } op_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_ADD = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;

  // beq compares two registers, so it is the only I-type without an immediate B operand.
  function automatic logic uses_imm(input op_class_t cls);
    return (cls == CLS_IMM_ALU) || (cls == CLS_LW) || (cls == CLS_SW);
  endfunction

endpackage

// File: rtl/mips_ctrl_fsm_if.sv
// Instruction handshake and control outputs of the MIPS control FSM.
interface mips_ctrl_fsm_if;
    import mips_ctrl_fsm_pkg::*;

    // instr_valid/instr_ready: an instruction transfers on a rising clk edge where
    // both are high; opcode/funct must be stable while instr_valid is high, and
    // instr_ready never depends combinationally on instr_valid.
    logic       instr_valid;
    logic       instr_ready;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;

    logic [2:0] alu_sel;
    logic       alu_src_imm;
    logic       reg_dst_rd;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch_taken;
    logic       done;
    logic       illegal;
    state_t     dbg_state;

    modport master (
        output instr_valid, opcode, funct, alu_zero,
        input  instr_ready, alu_sel, alu_src_imm, reg_dst_rd, reg_write,
               mem_read, mem_write, branch_taken, done, illegal, dbg_state
    );

    modport slave (
        input  instr_valid, opcode, funct, alu_zero,
        output instr_ready, alu_sel, alu_src_imm, reg_dst_rd, reg_write,
               mem_read, mem_write, branch_taken, done, illegal, dbg_state
    );

endinterface

// File: rtl/mips_ctrl_fsm_alu_op_decode.sv
// Purely combinational decode of a captured opcode/funct into ALU select,
// instruction class and an illegal flag.
module alu_op_decode
    import mips_ctrl_fsm_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_sel,
    output op_class_t  o_op_class,
    output logic       o_illegal
);

    always_comb begin
        o_alu_sel  = ALU_AND;
        o_op_class = CLS_RTYPE;
        o_illegal  = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_AND:  o_alu_sel = ALU_AND;
                    FN_OR:   o_alu_sel = ALU_OR;
                    FN_XOR:  o_alu_sel = ALU_XOR;
                    FN_NOR:  o_alu_sel = ALU_NOR;
                    FN_ADD:  o_alu_sel = ALU_ADD;
                    FN_SUB:  o_alu_sel = ALU_SUB;
                    FN_SLT:  o_alu_sel = ALU_SLT;
                    default: o_illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                o_op_class = CLS_IMM_ALU;
                o_alu_sel  = ALU_ADD;
            end
            OP_ANDI: begin
                o_op_class = CLS_IMM_ALU;
                o_alu_sel  = ALU_AND;
            end
            OP_ORI: begin
                o_op_class = CLS_IMM_ALU;
                o_alu_sel  = ALU_OR;
            end
            OP_XORI: begin
                o_op_class = CLS_IMM_ALU;
                o_alu_sel  = ALU_XOR;
            end
            OP_SLTI: begin
                o_op_class = CLS_IMM_ALU;
                o_alu_sel  = ALU_SLT;
            end
            // Loads and stores compute base + offset.
            OP_LW: begin
                o_op_class = CLS_LW;
                o_alu_sel  = ALU_ADD;
            end
            OP_SW: begin
                o_op_class = CLS_SW;
                o_alu_sel  = ALU_ADD;
            end
            OP_BEQ: begin
                o_op_class = CLS_BEQ;
                o_alu_sel  = ALU_SUB;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: accepts one instruction in IDLE and steps it
// through DECODE/EXEC/MEM/WB, emitting one-cycle control pulses.
module mips_ctrl_fsm
    import mips_ctrl_fsm_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    mips_ctrl_fsm_if.slave bus
);

    state_t     r_state;
    state_t     w_next_state;
    logic [5:0] r_opcode;
    logic [5:0] r_funct;

    logic [2:0] w_dec_sel;
    op_class_t  w_op_class;
    logic       w_illegal;

    logic       w_instr_ready;
    logic       w_accept;
    logic [2:0] w_alu_sel;
    logic       w_alu_src_imm;
    logic       w_reg_dst_rd;
    logic       w_reg_write;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_branch_taken;
    logic       w_done;
    logic       w_illegal_pulse;

    // Decode runs on the captured fields so a changing bus cannot disturb an in-flight instruction.
    alu_op_decode u_dec (
        .i_opcode   (r_opcode),
        .i_funct    (r_funct),
        .o_alu_sel  (w_dec_sel),
        .o_op_class (w_op_class),
        .o_illegal  (w_illegal)
    );

    assign w_accept = bus.instr_valid && w_instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_opcode <= '0;
            r_funct  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_opcode <= bus.opcode;
                r_funct  <= bus.funct;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next_state = ST_DECODE;
            ST_DECODE: w_next_state = w_illegal ? ST_IDLE : ST_EXEC;
            ST_EXEC: begin
                case (w_op_class)
                    CLS_LW, CLS_SW: w_next_state = ST_MEM;
                    CLS_BEQ:        w_next_state = ST_IDLE;
                    default:        w_next_state = ST_WB;
                endcase
            end
            ST_MEM:    w_next_state = (w_op_class == CLS_LW) ? ST_WB : ST_IDLE;
            ST_WB:     w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_instr_ready   = 1'b0;
        w_alu_sel       = ALU_AND;
        w_alu_src_imm   = 1'b0;
        w_reg_dst_rd    = 1'b0;
        w_reg_write     = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_branch_taken  = 1'b0;
        w_done          = 1'b0;
        w_illegal_pulse = 1'b0;
        case (r_state)
            // The state register already sits in IDLE during reset; gating keeps ready low too.
            ST_IDLE: w_instr_ready = rst_n;
            ST_DECODE: begin
                if (w_illegal) begin
                    w_illegal_pulse = 1'b1;
                    w_done          = 1'b1;
                end
            end
            ST_EXEC: begin
                w_alu_sel     = w_dec_sel;
                w_alu_src_imm = uses_imm(w_op_class);
                if (w_op_class == CLS_BEQ) begin
                    w_branch_taken = bus.alu_zero;
                    w_done         = 1'b1;
                end
            end
            ST_MEM: begin
                if (w_op_class == CLS_LW) begin
                    w_mem_read = 1'b1;
                end else begin
                    w_mem_write = 1'b1;
                    w_done      = 1'b1;
                end
            end
            ST_WB: begin
                w_reg_write  = 1'b1;
                w_done       = 1'b1;
                w_reg_dst_rd = (w_op_class == CLS_RTYPE);
            end
            default: ;
        endcase
    end

    assign bus.instr_ready  = w_instr_ready;
    assign bus.alu_sel      = w_alu_sel;
    assign bus.alu_src_imm  = w_alu_src_imm;
    assign bus.reg_dst_rd   = w_reg_dst_rd;
    assign bus.reg_write    = w_reg_write;
    assign bus.mem_read     = w_mem_read;
    assign bus.mem_write    = w_mem_write;
    assign bus.branch_taken = w_branch_taken;
    assign bus.done         = w_done;
    assign bus.illegal      = w_illegal_pulse;
    assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Directed bench for mips_ctrl_fsm: the driver pushes an expected record per
// instruction, and a monitor pops and checks it when done appears.
module tb_mips_ctrl_fsm;

  typedef struct packed {
    logic [7:0] lat;
    logic       gap_chk;
    logic [2:0] sel;
    logic       imm;
    logic       mrd;
    logic       mwr;
    logic       rw;
    logic       rd;
    logic       br;
    logic       ill;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   n_done_seen = 0;
  exp_t exp_q[$];

  mips_ctrl_fsm_if bus ();

  mips_ctrl_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int lat, input bit gap_chk, input logic [2:0] sel,
                              input bit imm, input bit mrd, input bit mwr, input bit rw,
                              input bit rd, input bit br, input bit ill);
    exp_t e;
    e.lat = 8'(lat); e.gap_chk = gap_chk; e.sel = sel; e.imm = imm;
    e.mrd = mrd; e.mwr = mwr; e.rw = rw; e.rd = rd; e.br = br; e.ill = ill;
    return e;
  endfunction

  // driver tasks: called at posedge+#1, return at posedge+#1 just after the accept edge
  task automatic offer(input logic [5:0] op, input logic [5:0] fn, input logic zero);
    bit got = 0;
    bus.instr_valid = 1'b1;
    bus.opcode      = op;
    bus.funct       = fn;
    bus.alu_zero    = zero;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.instr_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("offer_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.instr_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain_pending", exp_q.size(), 32'd0);
  endtask

  task automatic chk_all_low(input string name);
    chk({name, "_ready"}, bus.instr_ready, 1'b0);
    chk({name, "_alu_sel"}, bus.alu_sel, 3'b000);
    chk({name, "_pulses"}, {bus.alu_src_imm, bus.reg_dst_rd, bus.reg_write, bus.mem_read,
                            bus.mem_write, bus.branch_taken, bus.done, bus.illegal}, 8'h00);
    chk({name, "_state"}, bus.dbg_state, 3'd0);
  endtask

  // scoreboard monitor: samples on the falling edge
  initial begin : monitor
    bit   active = 0;
    int   off = 0;
    int   cyc = 0;
    int   last_done = 0;
    int   acc_gap = 0;
    int   n_rw, n_mrd, n_mwr, n_br, n_ill, n_stray;
    logic [2:0] s_sel;
    logic s_imm, s_mrd, s_mwr;
    exp_t e;
    n_rw = 0; n_mrd = 0; n_mwr = 0; n_br = 0; n_ill = 0; n_stray = 0;
    s_sel = '0; s_imm = 0; s_mrd = 0; s_mwr = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        active = 0;
        continue;
      end
      if (active) begin
        off++;
        if (off == 2) begin s_sel = bus.alu_sel; s_imm = bus.alu_src_imm; end
        if (off == 3) begin s_mrd = bus.mem_read; s_mwr = bus.mem_write; end
        n_rw  += int'(bus.reg_write);
        n_mrd += int'(bus.mem_read);
        n_mwr += int'(bus.mem_write);
        n_br  += int'(bus.branch_taken);
        n_ill += int'(bus.illegal);
        if (bus.alu_sel != 3'b000 && off != 2) n_stray++;
        if (bus.mem_read && bus.mem_write) n_stray++;
        if (bus.reg_dst_rd && !bus.reg_write) n_stray++;
        if (bus.done) begin
          n_done_seen++;
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("latency", off, e.lat);
            if (e.lat >= 2) begin
              chk("exec_alu_sel", s_sel, e.sel);
              chk("exec_alu_src_imm", s_imm, e.imm);
            end
            if (e.lat >= 3) begin
              chk("mem_read_cyc3", s_mrd, e.mrd);
              chk("mem_write_cyc3", s_mwr, e.mwr);
            end
            chk("reg_write_count", n_rw, e.rw);
            chk("mem_read_count", n_mrd, e.mrd);
            chk("mem_write_count", n_mwr, e.mwr);
            chk("branch_taken", n_br, e.br);
            chk("illegal_count", n_ill, e.ill);
            chk("reg_dst_rd_at_done", bus.reg_dst_rd, e.rd);
            chk("stray_outputs", n_stray, 32'd0);
            if (e.gap_chk) chk("accept_gap", acc_gap, 32'd1);
          end
          active = 0;
          last_done = cyc;
        end
      end else if (bus.done || bus.reg_write || bus.mem_read || bus.mem_write ||
                   bus.illegal || bus.branch_taken) begin
        chk("pulse_while_idle", 32'd1, 32'd0);
      end
      if (bus.instr_valid && bus.instr_ready) begin
        if (active) chk("accept_while_busy", 32'd1, 32'd0);
        active = 1;
        off = 0;
        acc_gap = cyc - last_done;
        n_rw = 0; n_mrd = 0; n_mwr = 0; n_br = 0; n_ill = 0; n_stray = 0;
        s_sel = '0; s_imm = 0; s_mrd = 0; s_mwr = 0;
      end
    end
  end

  // directed stimulus
  initial begin : stim
    int done_before;
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.opcode = 6'b0;
    bus.funct = 6'b0;
    bus.alu_zero = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_low("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", bus.instr_ready, 1'b1);
    chk("post_reset_state", bus.dbg_state, 3'd0);
    @(posedge clk);
    #1;

    // R-type: lat, gap, sel, imm, mrd, mwr, rw, rd, br, ill
    exp_q.push_back(mk(3, 0, 3'b101, 0, 0, 0, 1, 1, 0, 0)); offer(6'b000000, 6'b100000, 0); drain(); // add
    exp_q.push_back(mk(3, 0, 3'b100, 0, 0, 0, 1, 1, 0, 0)); offer(6'b000000, 6'b101010, 0); drain(); // slt
    exp_q.push_back(mk(3, 0, 3'b110, 0, 0, 0, 1, 1, 0, 0)); offer(6'b000000, 6'b100010, 0); drain(); // sub
    exp_q.push_back(mk(3, 0, 3'b011, 0, 0, 0, 1, 1, 0, 0)); offer(6'b000000, 6'b100111, 0); drain(); // nor
    exp_q.push_back(mk(3, 0, 3'b000, 0, 0, 0, 1, 1, 0, 0)); offer(6'b000000, 6'b100100, 0); drain(); // and
    exp_q.push_back(mk(3, 0, 3'b010, 0, 0, 0, 1, 1, 0, 0)); offer(6'b000000, 6'b100110, 0); drain(); // xor

    // I-type ALU ops
    exp_q.push_back(mk(3, 0, 3'b101, 1, 0, 0, 1, 0, 0, 0)); offer(6'b001000, 6'b111111, 0); drain(); // addi
    exp_q.push_back(mk(3, 0, 3'b000, 1, 0, 0, 1, 0, 0, 0)); offer(6'b001100, 6'b000000, 0); drain(); // andi
    exp_q.push_back(mk(3, 0, 3'b010, 1, 0, 0, 1, 0, 0, 0)); offer(6'b001110, 6'b000000, 0); drain(); // xori
    exp_q.push_back(mk(3, 0, 3'b100, 1, 0, 0, 1, 0, 0, 0)); offer(6'b001010, 6'b000000, 0); drain(); // slti

    // lw
    exp_q.push_back(mk(4, 0, 3'b101, 1, 1, 0, 1, 0, 0, 0)); offer(6'b100011, 6'b000000, 0); drain();

    // beq taken, then not taken
    exp_q.push_back(mk(2, 0, 3'b110, 0, 0, 0, 0, 0, 1, 0)); offer(6'b000100, 6'b000000, 1); drain();
    exp_q.push_back(mk(2, 0, 3'b110, 0, 0, 0, 0, 0, 0, 0)); offer(6'b000100, 6'b000000, 0); drain();

    // illegal opcode with instr_valid held high into the next add
    exp_q.push_back(mk(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1));
    exp_q.push_back(mk(3, 1, 3'b101, 0, 0, 0, 1, 1, 0, 0));
    offer(6'b111111, 6'b000000, 0);
    offer(6'b000000, 6'b100000, 0);
    drain();

    // illegal funct under R-type
    exp_q.push_back(mk(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1)); offer(6'b000000, 6'b000000, 0); drain();

    // back-to-back sw then ori; ori changes the bus while sw is in flight
    exp_q.push_back(mk(3, 0, 3'b101, 1, 0, 1, 0, 0, 0, 0));
    exp_q.push_back(mk(3, 1, 3'b001, 1, 0, 0, 1, 0, 0, 0));
    offer(6'b101011, 6'b000000, 0);
    offer(6'b001101, 6'b000000, 0);
    drain();

    // reset in EXEC of an add: no done, everything low at once
    done_before = n_done_seen;
    offer(6'b000000, 6'b100000, 0);
    bus.instr_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_low("mid_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_reset_ready", bus.instr_ready, 1'b1);
    chk("mid_reset_state", bus.dbg_state, 3'd0);
    repeat (4) @(negedge clk);
    chk("mid_reset_no_done", n_done_seen, done_before);
    @(posedge clk);
    #1;

    // machine still works after the mid-flight reset
    exp_q.push_back(mk(3, 0, 3'b001, 0, 0, 0, 1, 1, 0, 0)); offer(6'b000000, 6'b100101, 0); drain(); // or

    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
